// File: rtl/psum_spad.sv
// Partial-sum scratchpad: 32-entry signed register file with accumulate, write-first read and a registered valid/ready output.
// Define PSUM_SPAD_SAT_EN to clamp overflowing accumulates instead of wrapping.
module psum_spad #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              acc,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              out_ready,
    output logic              stall,
    output logic              ovf
);

    // state  | meaning
    // S_IDLE | output register empty (rd_valid=0)
    // S_HOLD | output register holds an unconsumed result (rd_valid=1)
    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_ovf;

    logic [DATA_W-1:0]  w_old;
    logic [DATA_W-1:0]  w_sum;
    logic [DATA_W-1:0]  w_acc_val;
    logic [DATA_W-1:0]  w_wr_val;
    logic [DATA_W-1:0]  w_rd_val;
    logic               w_ovf_det;
    logic               w_wr_go;
    logic               w_accept;
    logic               w_xfer;

    assign w_old     = r_vld[wr_addr] ? r_mem[wr_addr] : '0;
    assign w_sum     = w_old + wr_data;
    assign w_ovf_det = acc & (w_old[DATA_W-1] == wr_data[DATA_W-1])
                           & (w_sum[DATA_W-1] != w_old[DATA_W-1]);

`ifdef PSUM_SPAD_SAT_EN
    assign w_acc_val = !w_ovf_det      ? w_sum :
                       w_old[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                         {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign w_acc_val = w_sum;
`endif

    assign w_wr_val = acc ? w_acc_val : wr_data;
    assign w_wr_go  = wr_en & ~clear;
    assign w_accept = rd_en & (~rd_valid | out_ready);
    assign w_xfer   = rd_valid & out_ready;

    // Write-first forwarding so a same-cycle accumulate is visible to the read.
    always_comb begin
        w_rd_val = '0;
        if (clear)
            w_rd_val = '0;
        else if (w_wr_go && (wr_addr == rd_addr))
            w_rd_val = w_wr_val;
        else if (r_vld[rd_addr])
            w_rd_val = r_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (w_wr_go)
            r_mem[wr_addr] <= w_wr_val;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_vld <= '0;
            r_ovf <= 1'b0;
        end else if (w_wr_go) begin
            r_vld[wr_addr] <= 1'b1;
            if (w_ovf_det)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_rd_data <= w_rd_val;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_xfer && !w_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign rd_valid = (r_state == S_HOLD);
    assign rd_data  = r_rd_data;
    assign stall    = rd_valid & ~out_ready;
    assign ovf      = r_ovf;

endmodule

// File: doc/psum_spad.md
# psum_spad

Partial-sum scratchpad for one PE: a 32-entry signed register file, written or accumulated at the write address and read at the read address from the psum write/read address counter. Sits directly downstream of that counter: its `count` drives `wr_addr` and its `read_count` drives `rd_addr`. Read results go to the next PE or GLB through a registered valid/ready output. A `stall` output holds the counter's `read_en` off while the output is back-pressured.

## Interface
- `DATA_W`, 16: psum width, signed two's complement.
- `DEPTH`, 32: entry count; fixed at 2^`ADDR_W`.
- `ADDR_W`, 5: address width, matching the counter outputs.

- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous; invalidates all entries and clears `ovf`.
- `wr_en`  in  1  write/accumulate request.
- `wr_addr`  in  `ADDR_W`  write address (counter `count`).
- `wr_data`  in  `DATA_W`  write operand.
- `acc`  in  1  1 = add `wr_data` to the stored entry; 0 = overwrite.
- `rd_en`  in  1  read request (counter `read_en`).
- `rd_addr`  in  `ADDR_W`  read address (counter `read_count`).
- `rd_data`  out  `DATA_W`  registered read result.
- `rd_valid`  out  1  `rd_data` holds an unconsumed result.
- `out_ready`  in  1  downstream accepts `rd_data` this cycle.
- `stall`  out  1  = `rd_valid & ~out_ready`; gates upstream `read_en`.
- `ovf`  out  1  sticky arithmetic-overflow flag.

## Operation
- Storage: `DEPTH` x `DATA_W` flops plus one valid bit per entry.
  - Data flops are not reset.
  - Valid bits reset to 0.
  - An entry whose valid bit is 0 reads as 0.
- Write, when `wr_en` is high and `clear` is low:
  - `acc=0`: entry <= `wr_data`.
  - `acc=1`: entry <= old + `wr_data`, where old is 0 if the entry is invalid.
  - In both cases the entry's valid bit is set.
  - Read-modify-write completes in a single cycle; back-to-back accumulates to the same address have no hazard.
- Arithmetic: signed `DATA_W`-bit addition. Overflow is detected when the operand signs are equal and the result sign differs; detection sets `ovf`.
  - Without the macro, the result wraps modulo 2^`DATA_W`.
- Read acceptance: a read is accepted when `rd_en & (~rd_valid | out_ready)`. An accepted read loads `rd_data` and sets `rd_valid`.
- Output handshake:
  - A transfer occurs when `rd_valid & out_ready`.
  - A transfer with no new accepted read clears `rd_valid`.
  - `rd_en` while stalled is ignored. The read is not queued; upstream must hold it by honouring `stall`.
- Write/read collision (same cycle, same address): write-first. `rd_data` captures the post-write value, including the accumulated result.
- `clear`:
  - Invalidates all entries and zeroes `ovf`.
  - Takes priority over a same-cycle write, which is dropped.
  - A same-cycle accepted read returns 0.
  - The output register (`rd_data`/`rd_valid`) is not affected, so a pending result still drains.
- Output state: IDLE (`rd_valid=0`) and HOLD (`rd_valid=1`).
  - IDLE -> HOLD on an accepted read.
  - HOLD -> HOLD on transfer plus accepted read, or on no transfer.
  - HOLD -> IDLE on transfer with no accepted read.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `ovf`=0, all valid bits 0. `stall`=0 follows from these.
- Asynchronous assert takes effect immediately, mid-operation included. Any in-flight output is discarded.
- Write latency: a write on edge N is visible to a read accepted on edge N (forwarded) or later.
- Read latency: 1 cycle. `rd_en` sampled at edge N gives `rd_data`/`rd_valid` valid after edge N.
- Full throughput is one read per cycle while `out_ready` stays high.
- `stall` is combinational from registered `rd_valid` and the input `out_ready`.
- `ovf` is registered and asserts the cycle after the overflowing write.
- Address wrap is owned by the counter. Any address 0..31 is legal every cycle.

## Configuration
- `PSUM_SPAD_SAT_EN` defined: on overflow the stored result clamps to +2^(`DATA_W`-1)-1 or -2^(`DATA_W`-1), and `ovf` is still set.
- `PSUM_SPAD_SAT_EN` undefined: the result wraps, and `ovf` is set.
- The macro has no effect on ports or timing.

## Test plan
- Reset, then read addr 7 with `out_ready`=1: `rd_data`=0, `rd_valid`=1 for one cycle; `ovf`=0.
- Write addr 3 = 100 (`acc`=0), then accumulate addr 3 with +25 and -5 on consecutive cycles, then read: `rd_data`=120.
- Same-cycle accumulate of +7 to addr 5 (holding 10) and read of addr 5: `rd_data`=17.
- Hold `out_ready`=0 with `rd_valid`=1:
  - `stall`=1 and `rd_en` is ignored; `rd_data` is unchanged.
  - Raising `out_ready` lets the held value transfer, and the next read is accepted in the same cycle.
- Write addr 0 = 32767 then accumulate +1:
  - Without the macro: 0x8000 (-32768), `ovf`=1.
  - With `PSUM_SPAD_SAT_EN`: 32767, `ovf`=1.
- Pulse `clear` with a same-cycle write to addr 2: later reads of addr 2 return 0; `ovf`=0. Assert `rstn` low mid-burst: `rd_valid` drops to 0 immediately.
